// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: start, DATA_BITS data (LSB first), optional parity, one stop bit.
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | verifying start bit at its midpoint (sc==7)
// DATA      | sampling data bits at each midpoint (sc==15)
// PARITY    | sampling parity bit
// STOP      | sampling stop bit, then strobing done_r/errors
// WAIT_IDLE | stop bit was low; hold off until line is high for a full tick
module uart_rx_os16 #(
  parameter int CLKS_PER_TICK = 4,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_EN     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 done_r,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 error,
  output logic                 busy
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t               state;
  logic                 rx_meta, rxs, rxs_d;
  logic [TW-1:0]        tcnt;
  logic                 tick;
  logic [3:0]           sc;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_bit;
  logic                 armed;
  logic                 fall;
  logic                 par_exp;
  logic                 par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign fall    = rxs_d & ~rxs;
  assign tick    = (tcnt == TW'(CLKS_PER_TICK - 1));
  assign par_exp = (^data_sh) ^ (PARITY_ODD != 0);
  assign par_bad = (PARITY_EN != 0) && (par_bit != par_exp);
  assign busy    = (state != IDLE);

  // Restarting the tick phase at the start edge keeps midpoints centred on each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcnt <= '0;
    else if ((state == IDLE && fall) || tick)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sc         <= 4'd0;
      bit_idx    <= 3'd0;
      data_sh    <= '0;
      par_bit    <= 1'b0;
      armed      <= 1'b0;
      rx_data    <= '0;
      done_r     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      error      <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      error      <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            sc    <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (sc == 4'd7) begin
              sc <= 4'd0;
              if (!rxs) begin
                state   <= DATA;
                bit_idx <= 3'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc               <= 4'd0;
              data_sh[bit_idx] <= rxs;
              bit_idx          <= bit_idx + 3'd1;
              if (bit_idx == 3'(DATA_BITS - 1))
                state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc      <= 4'd0;
              par_bit <= rxs;
              state   <= STOP;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sc == 4'd15) begin
              sc         <= 4'd0;
              rx_data    <= data_sh;
              done_r     <= 1'b1;
              parity_err <= par_bad;
              frame_err  <= ~rxs;
              error      <= par_bad | ~rxs;
              armed      <= 1'b0;
              state      <= rxs ? IDLE : WAIT_IDLE;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          // armed means rxs has stayed high since the previous tick boundary
          if (!rxs)
            armed <= 1'b0;
          else if (tick) begin
            if (armed)
              state <= IDLE;
            else
              armed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
